// File: rtl/operand_stage_pkg.sv
// operand_stage_pkg: shared opcode-field and state encodings for the operand stage,
// plus the decoded instruction-class payload.
// Provides the `REG_WIDTH/`ADDR_WIDTH defaults, the opcode field macros
// (`CC_GRP1, `CC_GRP2, `AAA_STA, `BBB_IMM_ACC) and state encodings `OS_IDLE..`OS_DONE.
// Optional feature macro (consumed by operand_stage): `RMW_DUMMY_WRITE_EN.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

`ifndef CC_GRP1
`define CC_GRP1 2'b01
`endif
`ifndef CC_GRP2
`define CC_GRP2 2'b10
`endif
`ifndef AAA_STA
`define AAA_STA 3'b100
`endif
`ifndef BBB_IMM_ACC
`define BBB_IMM_ACC 3'b010
`endif

`ifndef OS_IDLE
`define OS_IDLE  3'd0
`define OS_READ  3'd1
`define OS_RWAIT 3'd2
`define OS_EXEC  3'd3
`define OS_RES   3'd4
`define OS_DUMMY 3'd5
`define OS_WRITE 3'd6
`define OS_DONE  3'd7
`endif

package operand_stage_pkg;

  localparam int unsigned OPC_WIDTH   = 8;
  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [2:0] S_IDLE  = `OS_IDLE;
  localparam logic [2:0] S_READ  = `OS_READ;
  localparam logic [2:0] S_RWAIT = `OS_RWAIT;
  localparam logic [2:0] S_EXEC  = `OS_EXEC;
  localparam logic [2:0] S_RES   = `OS_RES;
  localparam logic [2:0] S_DUMMY = `OS_DUMMY;
  localparam logic [2:0] S_WRITE = `OS_WRITE;
  localparam logic [2:0] S_DONE  = `OS_DONE;

  // Decoded instruction class.
  typedef struct packed {
    logic load;
    logic store;
    logic rmw;
    logic use_imm;
    logic use_acc;
    logic bad;
  } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// op_class_decode: combinational opcode classifier.
// Ports: opcode (in, 8) -> op_class_c (out, op_class_t {load, store, rmw, use_imm, use_acc, bad}).

module op_class_decode
  import operand_stage_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] opcode,
  output op_class_t            op_class_c
);

  logic [1:0] cc;
  logic [2:0] aaa;
  logic [2:0] bbb;

  assign cc  = opcode[1:0];
  assign aaa = opcode[7:5];
  assign bbb = opcode[4:2];

  // Classify by cc/aaa/bbb fields.
  always_comb begin
    op_class_c = '0;
    if (cc == `CC_GRP1) begin
      if (aaa != `AAA_STA) begin
        op_class_c.load    = 1'b1;
        op_class_c.use_imm = (bbb == `BBB_IMM_ACC);
      end else if (bbb != `BBB_IMM_ACC) begin
        op_class_c.store = 1'b1;
      end
    end else if (cc == `CC_GRP2) begin
      // bbb 000/100/110 carry no shift/inc/dec addressing mode (e.g. 02 is a halt opcode).
      if ((aaa != 3'b100) && (aaa != 3'b101) &&
          (bbb != 3'b000) && (bbb != 3'b100) && (bbb != 3'b110)) begin
        if (bbb == `BBB_IMM_ACC) begin
          // Accumulator mode exists only for ASL/ROL/LSR/ROR.
          if (aaa <= 3'b011) begin
            op_class_c.rmw     = 1'b1;
            op_class_c.use_acc = 1'b1;
          end
        end else begin
          op_class_c.rmw = 1'b1;
        end
      end
    end
    op_class_c.bad = ~(op_class_c.load | op_class_c.store | op_class_c.rmw);
  end

endmodule

// File: rtl/operand_stage.sv
// operand_stage: memory-operand and write-back sequencer behind the instruction fetcher.
// Accepts an instruction (opcode, effective address, immediate, accumulator), performs the
// operand read, hands the operand to execute over op_valid/op_ready, performs the store or
// RMW write-back, then pulses instruction_done to re-arm the fetcher.
// Ports: phi1, reset_n (async active-low); fetch side instruction_ready/instruction_in/
// addr_in/imm_in/acc_in; memory mem_addr/mem_re/mem_we/mem_wdata/mem_rdata; execute side
// op_valid/op_code/op_data/op_ready/res_valid/res_data; status instruction_done/busy/bad_op.
// Optional macro `RMW_DUMMY_WRITE_EN: memory RMW writes the unmodified value first (DUMMY).

module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = `REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [OPC_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  acc_in,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic                  op_ready,
  input  logic                  res_valid,
  input  logic [REG_WIDTH-1:0]  res_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  op_valid,
  output logic [OPC_WIDTH-1:0]  op_code,
  output logic [REG_WIDTH-1:0]  op_data,
  output logic                  instruction_done,
  output logic                  busy,
  output logic                  bad_op
);

  op_class_t dec_c;

  op_class_decode u_decode (
    .opcode     (instruction_in),
    .op_class_c (dec_c)
  );

  logic [STATE_WIDTH-1:0] state, state_nxt;
  logic                   armed, armed_nxt;
  logic                   rmw_q, rmw_nxt;
  logic                   acc_mode_q, acc_mode_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
`ifdef RMW_DUMMY_WRITE_EN
  logic [REG_WIDTH-1:0]   res_q, res_nxt;
`endif

  logic [ADDR_WIDTH-1:0]  mem_addr_nxt;
  logic                   mem_re_nxt;
  logic                   mem_we_nxt;
  logic [REG_WIDTH-1:0]   mem_wdata_nxt;
  logic                   op_valid_nxt;
  logic [OPC_WIDTH-1:0]   op_code_nxt;
  logic [REG_WIDTH-1:0]   op_data_nxt;
  logic                   done_nxt;
  logic                   busy_nxt;
  logic                   bad_nxt;

  // State, context and registered outputs.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      armed            <= 1'b1;
      rmw_q            <= 1'b0;
      acc_mode_q       <= 1'b0;
      addr_q           <= '0;
`ifdef RMW_DUMMY_WRITE_EN
      res_q            <= '0;
`endif
      mem_addr         <= '0;
      mem_re           <= 1'b0;
      mem_we           <= 1'b0;
      mem_wdata        <= '0;
      op_valid         <= 1'b0;
      op_code          <= '0;
      op_data          <= '0;
      instruction_done <= 1'b0;
      busy             <= 1'b0;
      bad_op           <= 1'b0;
    end else begin
      state            <= state_nxt;
      armed            <= armed_nxt;
      rmw_q            <= rmw_nxt;
      acc_mode_q       <= acc_mode_nxt;
      addr_q           <= addr_nxt;
`ifdef RMW_DUMMY_WRITE_EN
      res_q            <= res_nxt;
`endif
      mem_addr         <= mem_addr_nxt;
      mem_re           <= mem_re_nxt;
      mem_we           <= mem_we_nxt;
      mem_wdata        <= mem_wdata_nxt;
      op_valid         <= op_valid_nxt;
      op_code          <= op_code_nxt;
      op_data          <= op_data_nxt;
      instruction_done <= done_nxt;
      busy             <= busy_nxt;
      bad_op           <= bad_nxt;
    end
  end

  // Next state and next output values; outputs reflect the state being entered.
  always_comb begin
    state_nxt     = state;
    // Re-arm whenever the fetcher drops instruction_ready, so a held request is not re-taken.
    armed_nxt     = armed | ~instruction_ready;
    rmw_nxt       = rmw_q;
    acc_mode_nxt  = acc_mode_q;
    addr_nxt      = addr_q;
`ifdef RMW_DUMMY_WRITE_EN
    res_nxt       = res_q;
`endif
    mem_addr_nxt  = mem_addr;
    mem_re_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_wdata_nxt = mem_wdata;
    op_valid_nxt  = 1'b0;
    op_code_nxt   = op_code;
    op_data_nxt   = op_data;
    done_nxt      = 1'b0;
    bad_nxt       = 1'b0;

    case (state)
      S_IDLE: begin
        if (instruction_ready && armed) begin
          armed_nxt    = 1'b0;
          rmw_nxt      = dec_c.rmw;
          acc_mode_nxt = dec_c.use_acc;
          addr_nxt     = addr_in;
          op_code_nxt  = instruction_in;
          if (dec_c.bad) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            bad_nxt   = 1'b1;
          end else if (dec_c.store) begin
            state_nxt     = S_WRITE;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = addr_in;
            mem_wdata_nxt = acc_in;
          end else if (dec_c.use_imm) begin
            state_nxt    = S_EXEC;
            op_valid_nxt = 1'b1;
            op_data_nxt  = imm_in;
          end else if (dec_c.use_acc) begin
            state_nxt    = S_EXEC;
            op_valid_nxt = 1'b1;
            op_data_nxt  = acc_in;
          end else if (dec_c.load || dec_c.rmw) begin
            state_nxt    = S_READ;
            mem_re_nxt   = 1'b1;
            mem_addr_nxt = addr_in;
          end
        end
      end
      S_READ: begin
        state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        state_nxt    = S_EXEC;
        op_valid_nxt = 1'b1;
        op_data_nxt  = mem_rdata;
      end
      S_EXEC: begin
        if (op_ready) begin
          if (rmw_q) begin
            state_nxt = S_RES;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          op_valid_nxt = 1'b1;
        end
      end
      S_RES: begin
        if (res_valid) begin
          if (acc_mode_q) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
`ifdef RMW_DUMMY_WRITE_EN
            // Write back the unmodified operand first, as the NMOS 6502 does.
            res_nxt       = res_data;
            state_nxt     = S_DUMMY;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = addr_q;
            mem_wdata_nxt = op_data;
`else
            state_nxt     = S_WRITE;
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = addr_q;
            mem_wdata_nxt = res_data;
`endif
          end
        end
      end
      S_DUMMY: begin
`ifdef RMW_DUMMY_WRITE_EN
        state_nxt     = S_WRITE;
        mem_we_nxt    = 1'b1;
        mem_addr_nxt  = addr_q;
        mem_wdata_nxt = res_q;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_WRITE: begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;

`ifdef RMW_DUMMY_WRITE_EN
  localparam int DW = 1;
`else
  localparam int DW = 0;
`endif

  logic        phi1;
  logic        reset_n;
  logic        instruction_ready;
  logic [7:0]  instruction_in;
  logic [15:0] addr_in;
  logic [7:0]  imm_in;
  logic [7:0]  acc_in;
  logic [7:0]  mem_rdata;
  logic        op_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        op_valid;
  logic [7:0]  op_code;
  logic [7:0]  op_data;
  logic        instruction_done;
  logic        busy;
  logic        bad_op;

  operand_stage dut (
    .phi1              (phi1),
    .reset_n           (reset_n),
    .instruction_ready (instruction_ready),
    .instruction_in    (instruction_in),
    .addr_in           (addr_in),
    .imm_in            (imm_in),
    .acc_in            (acc_in),
    .mem_rdata         (mem_rdata),
    .op_ready          (op_ready),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .mem_addr          (mem_addr),
    .mem_re            (mem_re),
    .mem_we            (mem_we),
    .mem_wdata         (mem_wdata),
    .op_valid          (op_valid),
    .op_code           (op_code),
    .op_data           (op_data),
    .instruction_done  (instruction_done),
    .busy              (busy),
    .bad_op            (bad_op)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  // Memory model: read data valid the cycle after mem_re.
  logic [7:0] mem [0:65535];
  always @(posedge phi1) if (mem_re) mem_rdata <= mem[mem_addr];

  int overlap = 0;
  always @(negedge phi1) if (reset_n && mem_re && mem_we) overlap++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  imm;
    logic [7:0]  acc;
    logic [7:0]  memv;
    logic [7:0]  res;
    int          stall;
    int          e_done;
    int          e_opv;
    logic [7:0]  e_opd;
    int          e_re;
    int          e_we;
    logic [7:0]  e_wfirst;
    logic [7:0]  e_wlast;
    logic        e_bad;
  } vec_t;

  vec_t vecs[12];

  // Apply one instruction; op_ready low for 'stall' EXEC cycles, res_valid held high.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc, done_cyc, opv_cyc, k, re_cnt, we_cnt, badaddr;
    logic [7:0] opd, wfirst, wlast;
    logic bad_seen;
    done_cyc = -1; opv_cyc = 0; k = 0; re_cnt = 0; we_cnt = 0; badaddr = 0;
    opd = 8'h00; wfirst = 8'h00; wlast = 8'h00; bad_seen = 1'b0;
    mem[v.addr]       = v.memv;
    instruction_in    = v.op;
    addr_in           = v.addr;
    imm_in            = v.imm;
    acc_in            = v.acc;
    res_data          = v.res;
    res_valid         = 1'b1;
    op_ready          = (v.stall == 0);
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      if (mem_re) begin
        re_cnt++;
        if (mem_addr != v.addr) badaddr++;
      end
      if (mem_we) begin
        if (we_cnt == 0) wfirst = mem_wdata;
        wlast = mem_wdata;
        we_cnt++;
        if (mem_addr != v.addr) badaddr++;
      end
      if (op_valid) begin
        k++;
        if (k == 1) begin
          opv_cyc = cyc;
          opd = op_data;
        end
        op_ready = (k > v.stall);
      end
      if (instruction_done) begin
        done_cyc = cyc;
        bad_seen = bad_op;
        break;
      end
      tick();
    end
    check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.e_done));
    check($sformatf("v%0d_bad_op", idx), 32'(bad_seen), 32'(v.e_bad));
    check($sformatf("v%0d_opvalid_cycle", idx), 32'(opv_cyc), 32'(v.e_opv));
    if (v.e_opv != 0) check($sformatf("v%0d_op_data", idx), 32'(opd), 32'(v.e_opd));
    check($sformatf("v%0d_read_count", idx), 32'(re_cnt), 32'(v.e_re));
    check($sformatf("v%0d_write_count", idx), 32'(we_cnt), 32'(v.e_we));
    if (v.e_we != 0) begin
      check($sformatf("v%0d_wdata_first", idx), 32'(wfirst), 32'(v.e_wfirst));
      check($sformatf("v%0d_wdata_last", idx), 32'(wlast), 32'(v.e_wlast));
    end
    check($sformatf("v%0d_addr_mismatches", idx), 32'(badaddr), 32'd0);
    tick();
    check($sformatf("v%0d_idle_after", idx), 32'({busy, instruction_done}), 32'd0);
  endtask

  initial begin
    int cyc, done_cyc, we_cnt;
    logic [7:0] wfirst, wlast;

    //        op     addr     imm    acc    memv   res  stall done  opv  opd   re we      wfirst                wlast  bad
    vecs[0]  = '{8'hA9, 16'h0000, 8'h42, 8'h00, 8'h00, 8'h00, 0, 2,    1, 8'h42, 0, 0,    8'h00,                8'h00, 1'b0}; // LDA #$42
    vecs[1]  = '{8'hA5, 16'h0010, 8'h00, 8'h00, 8'h7F, 8'h00, 0, 4,    3, 8'h7F, 1, 0,    8'h00,                8'h00, 1'b0}; // LDA $10
    vecs[2]  = '{8'h8D, 16'h0200, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 2,    0, 8'h00, 0, 1,    8'h3C,                8'h3C, 1'b0}; // STA $0200
    vecs[3]  = '{8'hE6, 16'h0033, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 8+DW, 3, 8'hFF, 1, 1+DW, (DW==1)?8'hFF:8'h00, 8'h00, 1'b0}; // INC $33
    vecs[4]  = '{8'h02, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,    0, 8'h00, 0, 0,    8'h00,                8'h00, 1'b1}; // halt
    vecs[5]  = '{8'h0A, 16'h0000, 8'h00, 8'h81, 8'h00, 8'h02, 0, 3,    1, 8'h81, 0, 0,    8'h00,                8'h00, 1'b0}; // ASL A
    vecs[6]  = '{8'h69, 16'h0000, 8'h05, 8'h00, 8'h00, 8'h00, 1, 3,    1, 8'h05, 0, 0,    8'h00,                8'h00, 1'b0}; // ADC #$05 stalled
    vecs[7]  = '{8'h89, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,    0, 8'h00, 0, 0,    8'h00,                8'h00, 1'b1}; // STA # (illegal)
    vecs[8]  = '{8'h6A, 16'h0000, 8'h00, 8'h10, 8'h00, 8'h08, 0, 3,    1, 8'h10, 0, 0,    8'h00,                8'h00, 1'b0}; // ROR A
    vecs[9]  = '{8'hCA, 16'h0000, 8'h00, 8'h10, 8'h00, 8'h00, 0, 1,    0, 8'h00, 0, 0,    8'h00,                8'h00, 1'b1}; // DEC A (illegal)
    vecs[10] = '{8'h4C, 16'h0300, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,    0, 8'h00, 0, 0,    8'h00,                8'h00, 1'b1}; // JMP, cc=00
    vecs[11] = '{8'h4E, 16'h1234, 8'h00, 8'h00, 8'h80, 8'h40, 0, 6+DW, 3, 8'h80, 1, 1+DW, (DW==1)?8'h80:8'h40, 8'h40, 1'b0}; // LSR $1234

    reset_n = 1'b0;
    instruction_ready = 1'b0;
    instruction_in = 8'h00;
    addr_in = 16'h0000;
    imm_in = 8'h00;
    acc_in = 8'h00;
    op_ready = 1'b0;
    res_valid = 1'b0;
    res_data = 8'h00;
    mem_rdata = 8'h00;
    repeat (2) @(posedge phi1);
    @(negedge phi1);
    reset_n = 1'b1;
    #1;
    check("reset_outputs", 32'({mem_addr, mem_re, mem_we, mem_wdata, op_valid}), 32'd0);
    check("reset_outputs2", 32'({op_code, op_data, instruction_done, busy, bad_op}), 32'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
      tick();
    end

    // Unsupported opcode with instruction_ready held high: no re-accept.
    instruction_in = 8'h02;
    instruction_ready = 1'b1;
    tick();
    check("hold_bad_done", 32'({instruction_done, bad_op}), 32'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_no_reaccept_%0d", i), 32'({busy, instruction_done, mem_re, mem_we}), 32'd0);
    end
    instruction_ready = 1'b0;
    tick();

    // Reset asserted in RES during ASL $0044.
    mem[16'h0044] = 8'h12;
    instruction_in = 8'h06;
    addr_in = 16'h0044;
    op_ready = 1'b1;
    res_valid = 1'b0;
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    tick();
    tick();
    check("rst_seq_exec", 32'({op_valid, op_data}), 32'h112);
    tick();
    check("rst_seq_in_res", 32'({busy, op_valid, mem_we}), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_seq_outputs", 32'({mem_addr, mem_re, mem_we, mem_wdata, op_valid}), 32'd0);
    check("rst_seq_outputs2", 32'({op_code, op_data, instruction_done, busy, bad_op}), 32'd0);
    res_valid = 1'b1;
    res_data = 8'h24;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_seq_held_%0d", i), 32'({mem_we, instruction_done, busy}), 32'd0);
    end
    @(negedge phi1);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_seq_idle_%0d", i), 32'({mem_we, instruction_done, busy}), 32'd0);
    end

    // res_valid during EXEC is ignored; only the value presented in RES is written.
    instruction_in = 8'h06;
    addr_in = 16'h0044;
    op_ready = 1'b0;
    res_valid = 1'b1;
    res_data = 8'hAA;
    instruction_ready = 1'b1;
    tick();                         // cycle 1: READ
    instruction_ready = 1'b0;
    tick();                         // cycle 2: RWAIT
    tick();                         // cycle 3: EXEC, op_ready low
    tick();                         // cycle 4: EXEC
    op_ready = 1'b1;
    res_valid = 1'b0;
    tick();                         // cycle 5: RES, res_valid low
    tick();                         // cycle 6: RES
    res_valid = 1'b1;
    res_data = 8'h55;
    done_cyc = -1; we_cnt = 0; wfirst = 8'h00; wlast = 8'h00;
    for (cyc = 7; cyc <= 20; cyc++) begin
      tick();
      if (mem_we) begin
        if (we_cnt == 0) wfirst = mem_wdata;
        wlast = mem_wdata;
        we_cnt++;
      end
      if (instruction_done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("exec_res_done_cycle", 32'(done_cyc), 32'(8 + DW));
    check("exec_res_write_count", 32'(we_cnt), 32'(1 + DW));
    check("exec_res_wdata_first", 32'(wfirst), (DW == 1) ? 32'h12 : 32'h55);
    check("exec_res_wdata_last", 32'(wlast), 32'h55);
    res_valid = 1'b0;
    tick();
    tick();

    check("re_we_overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Memory-operand and write-back sequencer that sits directly downstream of the instruction fetcher. It accepts a fetched instruction with its resolved effective address or immediate, and performs the operand read. It hands the operand to the execute unit over a valid/ready handshake and, for stores and read-modify-write instructions, performs the memory write. When the instruction completes it pulses `instruction_done`, which re-arms the fetcher.

## Interface
Parameters:
- `REG_WIDTH`, default `` `REG_WIDTH `` (8): data width.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (16): address width.

Ports:
- `phi1`  in  1: the single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `instruction_ready`  in  1: fetcher has a valid instruction, address and immediate.
- `instruction_in`  in  8: opcode.
- `addr_in`  in  16: effective address.
- `imm_in`  in  8: immediate operand.
- `acc_in`  in  8: accumulator value; store data for STA, operand for accumulator-mode shifts.
- `mem_rdata`  in  8: memory read data, valid the cycle after `mem_re`.
- `op_ready`  in  1: execute unit accepts the operand.
- `res_valid`  in  1: execute unit presents the RMW result.
- `res_data`  in  8: RMW result.
- `mem_addr`  out  16: memory address.
- `mem_re`  out  1: memory read strobe.
- `mem_we`  out  1: memory write strobe.
- `mem_wdata`  out  8: write data.
- `op_valid`  out  1: operand valid to the execute unit.
- `op_code`  out  8: latched opcode.
- `op_data`  out  8: operand.
- `instruction_done`  out  1: one-cycle completion pulse.
- `busy`  out  1: high in any state other than IDLE.
- `bad_op`  out  1: one-cycle pulse, coincident with `instruction_done`, for an unsupported opcode.

## Operation
- Every output is registered and resets to 0. The state register resets to IDLE, and the `armed` flag resets to 1.
- Accept rule: the block accepts in IDLE when `instruction_ready` and `armed` are both high.
  - On accept it latches `instruction_in`, `addr_in`, `imm_in` and `acc_in`, and clears `armed`.
  - `armed` sets again on any edge where `instruction_ready` is sampled low.
- Decode uses `cc` = bits [1:0], `aaa` = bits [7:5] and `bbb` = bits [4:2].
  - **Load:** `cc`=01 and `aaa`≠100 (ORA, AND, EOR, ADC, LDA, CMP, SBC). If `bbb`=010 the operand is the immediate; otherwise it is read from memory.
  - **Store:** `cc`=01 and `aaa`=100 (STA). `bbb`=010 is unsupported.
  - **RMW:** `cc`=10 and `aaa` in {000, 001, 010, 011, 110, 111}. If `bbb`=010 the operation is accumulator mode, which is legal only for `aaa`≤011.
  - Everything else is unsupported.
- States: IDLE, READ, RWAIT, EXEC, RES, DUMMY, WRITE, DONE.
  - **Load (memory):** IDLE → READ → RWAIT → EXEC → DONE.
  - **Load (immediate):** IDLE → EXEC → DONE.
  - **Store:** IDLE → WRITE → DONE.
  - **RMW (memory):** IDLE → READ → RWAIT → EXEC → RES → [DUMMY] → WRITE → DONE.
  - **RMW (accumulator):** IDLE → EXEC → RES → DONE, with no memory write.
  - **Unsupported:** IDLE → DONE, with `bad_op`=1.
- READ drives `mem_re`=1 and `mem_addr`=latched address. RWAIT captures `mem_rdata` into `op_data` at the end of the cycle.
- EXEC holds `op_valid`=1 with `op_data` and `op_code` stable until `op_ready` is sampled high, then leaves EXEC on that edge.
- RES waits for `res_valid` and captures `res_data`. A `res_valid` that arrives while in EXEC is ignored.
- WRITE drives `mem_we`=1, `mem_addr`=latched address, and `mem_wdata` = `res_data` (RMW) or the latched `acc_in` (store).
- DONE drives `instruction_done`=1 for exactly one cycle, then the block returns to IDLE.
- `mem_re` and `mem_we` are never high in the same cycle. All addresses pass through unmodified; this block does no address arithmetic.

## Timing
- Latency, from the accept edge at cycle 0 to `instruction_done` high, assuming zero wait from the execute unit:
  - Immediate load: cycle 2.
  - Memory load: cycle 4.
  - Store: cycle 2.
  - Memory RMW: cycle 6 (cycle 7 with `RMW_DUMMY_WRITE_EN`).
  - Accumulator RMW: cycle 3.
  - Unsupported opcode: cycle 1.
- Each cycle of `op_ready` low in EXEC, or `res_valid` low in RES, adds one cycle of latency.
- If `instruction_ready` is still high in the cycle after DONE, `armed` is low, so the block does not re-accept a stale instruction.
- Reset asserted mid-operation takes effect immediately. Any in-flight write is dropped, all strobes drop, and `instruction_done` is not issued.

## Configuration
- Macro: `` `RMW_DUMMY_WRITE_EN ``.
- **Defined:** memory RMW instructions pass through DUMMY. DUMMY drives `mem_we`=1 with `mem_wdata` = the originally read value, matching the NMOS 6502 double write. It is followed by WRITE with the modified value.
- **Undefined:** DUMMY is unreachable, and memory RMW goes directly from RES to WRITE.

## Structure
- Add to the shared defines file:
  - `` `CC_GRP1 `` (01) and `` `CC_GRP2 `` (10).
  - `` `AAA_STA `` (100).
  - `` `BBB_IMM_ACC `` (010).
  - The state encodings `` `OS_IDLE `` … `` `OS_DONE ``.
- One combinational sub-module, `op_class_decode`: opcode → {load, store, rmw, use_imm, use_acc, bad}.

## Test plan
- LDA #$42 (A9) with `imm_in`=42 and `op_ready` tied high → `op_data`=42 with `op_valid` at cycle 1, `instruction_done` at cycle 2, `mem_re` never high.
- LDA $0010 (A5), with memory[0010]=7F → `mem_re` with `mem_addr`=0010 at cycle 1, `op_data`=7F at cycle 3, `instruction_done` at cycle 4.
- STA $0200 (8D) with `acc_in`=3C → `mem_we`, `mem_addr`=0200, `mem_wdata`=3C at cycle 1, `instruction_done` at cycle 2.
- INC $0033 (E6), memory=FF, `res_data`=00 returned after `op_ready` is held low for 2 cycles → write of 00 to 0033, `instruction_done` at cycle 8. With `RMW_DUMMY_WRITE_EN` defined, a preceding write of FF is also required.
- Opcode 02 → `bad_op` and `instruction_done` at cycle 1, no memory strobes. `instruction_ready` held high afterwards → no re-accept.
- `reset_n` pulled low in RES during ASL $0044 → all outputs 0, no `mem_we`, no `instruction_done`, state IDLE.
